// File: rtl/alu_control_sequencer_pkg.sv
// Shared definitions for the ALU control sequencer.
//   - ALU function-select (FS) encodings and flag bit order {D,N,V,C,Z}
//   - control-class op codes, register-file write-source codes
//   - sequencer state encoding
//   - helper: is_shift_fs() identifies FS codes that consume the shift amount
package alu_control_sequencer_pkg;

  localparam logic [3:0] FS_TSA  = 4'h0;
  localparam logic [3:0] FS_INC  = 4'h1;
  localparam logic [3:0] FS_ADD  = 4'h2;
  localparam logic [3:0] FS_ADDC = 4'h3;
  localparam logic [3:0] FS_SUB  = 4'h4;
  localparam logic [3:0] FS_SUBB = 4'h5;
  localparam logic [3:0] FS_DEC  = 4'h6;
  localparam logic [3:0] FS_AND  = 4'h7;
  localparam logic [3:0] FS_OR   = 4'h8;
  localparam logic [3:0] FS_XOR  = 4'h9;
  localparam logic [3:0] FS_NOT  = 4'hA;
  localparam logic [3:0] FS_TSB  = 4'hB;
  localparam logic [3:0] FS_SHL  = 4'hC;
  localparam logic [3:0] FS_SHR  = 4'hD;
  localparam logic [3:0] FS_ROL  = 4'hE;
  localparam logic [3:0] FS_ROR  = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_D = 4;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JC   = 3'd3;
  localparam logic [2:0] OP_JN   = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_IN   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_IMM = 2'd1;
  localparam logic [1:0] WSEL_IN  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4,
    ST_PAUSE  = 3'd5
  } seq_state_e;

  // The four shift/rotate functions occupy the top quarter of the FS space.
  function automatic logic is_shift_fs(input logic [3:0] fs);
    return (fs[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_control_sequencer_decode.sv
// seq_instr_decode: combinational instruction decode for the sequencer.
// Ports:
//   ir            in   16  instruction register
//   flag_z/c/n    in   1   latched flags used for branch resolution
//   is_alu        out  1   instruction is ALU class ([15]=0)
//   fs, sh        out  4/3 ALU function select and shift amount
//   ra, rb, rd    out  3   register fields
//   imm           out  8   immediate / branch target (CTL class only)
//   writes_rf     out  1   instruction writes the register file in WB
//   wsel          out  2   write-data source
//   branch_taken  out  1   PC loads imm in WB
//   is_halt       out  1   HALT op
module seq_instr_decode
  import alu_control_sequencer_pkg::*;
(
  input  logic [15:0] ir,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_n,
  output logic        is_alu,
  output logic [3:0]  fs,
  output logic [2:0]  sh,
  output logic [2:0]  ra,
  output logic [2:0]  rb,
  output logic [2:0]  rd,
  output logic [7:0]  imm,
  output logic        writes_rf,
  output logic [1:0]  wsel,
  output logic        branch_taken,
  output logic        is_halt
);

  always_comb begin
    is_alu       = ~ir[15];
    fs           = 4'h0;
    sh           = 3'd0;
    ra           = 3'd0;
    rb           = 3'd0;
    rd           = ir[10:8];
    imm          = 8'h00;
    writes_rf    = 1'b0;
    wsel         = WSEL_ALU;
    branch_taken = 1'b0;
    is_halt      = 1'b0;

    if (!ir[15]) begin
      fs        = ir[14:11];
      ra        = ir[7:5];
      rb        = ir[4:2];
      // rb field doubles as the shift amount for shift/rotate functions
      sh        = is_shift_fs(ir[14:11]) ? ir[4:2] : 3'd0;
      writes_rf = 1'b1;
    end else begin
      imm = ir[7:0];
      case (ir[14:12])
        OP_JMP:  branch_taken = 1'b1;
        OP_JZ:   branch_taken = flag_z;
        OP_JC:   branch_taken = flag_c;
        OP_JN:   branch_taken = flag_n;
        OP_LDI: begin
          writes_rf = 1'b1;
          wsel      = WSEL_IMM;
        end
        OP_IN: begin
          writes_rf = 1'b1;
          wsel      = WSEL_IN;
        end
        OP_HALT: is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: multi-cycle fetch/decode/execute controller for the
// 8-bit datapath. Fetches 16-bit instructions, drives ALU FS/SH and register-
// file controls, latches ALU flags and resolves branches from them.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds input 'step'; after each WB
// the FSM waits in PAUSE until step=1.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   step                  single-step advance (SEQ_SINGLE_STEP_EN only)
//   imem_req/addr/ack/rdata   instruction fetch handshake
//   alu_fs, alu_sh        ALU function select / shift amount
//   alu_z/c/v/n/d         ALU flags (combinational from the ALU)
//   rf_ra, rf_rb          register-file read addresses
//   rf_we, rf_wa, rf_wsel register-file write pulse, address, data source
//   imm                   immediate for LDI
//   halted                high while in HALT
//   flags_q               latched {D,N,V,C,Z}
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_FETCH  | imem_req high, imem_addr=PC; IR loads on imem_ack
// ST_DECODE | IR fields drive ALU/RF read controls
// ST_EXEC   | ALU instr: flags_q captures ALU flags
// ST_WB     | rf_we pulse for ALU/LDI/IN; PC update
// ST_HALT   | absorbing until rst; no fetch, no writes
// ST_PAUSE  | single-step wait for step=1 (SEQ_SINGLE_STEP_EN only)
module alu_control_sequencer
  import alu_control_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [3:0]      alu_fs,
  output logic [2:0]      alu_sh,
  input  logic            alu_z,
  input  logic            alu_c,
  input  logic            alu_v,
  input  logic            alu_n,
  input  logic            alu_d,
  output logic [2:0]      rf_ra,
  output logic [2:0]      rf_rb,
  output logic            rf_we,
  output logic [2:0]      rf_wa,
  output logic [1:0]      rf_wsel,
  output logic [7:0]      imm,
  output logic            halted,
  output logic [4:0]      flags_q
);

  seq_state_e      state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;

  logic       dec_is_alu;
  logic [3:0] dec_fs;
  logic [2:0] dec_sh, dec_ra, dec_rb, dec_rd;
  logic [7:0] dec_imm;
  logic       dec_writes_rf, dec_taken, dec_is_halt;
  logic [1:0] dec_wsel;

  seq_instr_decode u_decode (
    .ir           (ir),
    .flag_z       (flags_q[FLAG_Z]),
    .flag_c       (flags_q[FLAG_C]),
    .flag_n       (flags_q[FLAG_N]),
    .is_alu       (dec_is_alu),
    .fs           (dec_fs),
    .sh           (dec_sh),
    .ra           (dec_ra),
    .rb           (dec_rb),
    .rd           (dec_rd),
    .imm          (dec_imm),
    .writes_rf    (dec_writes_rf),
    .wsel         (dec_wsel),
    .branch_taken (dec_taken),
    .is_halt      (dec_is_halt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    rf_we     = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = ~rst;
        if (imem_ack) state_nxt = ST_DECODE;
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB: begin
        rf_we = dec_writes_rf & ~rst;
        if (dec_is_halt) state_nxt = ST_HALT;
`ifdef SEQ_SINGLE_STEP_EN
        else             state_nxt = ST_PAUSE;
`else
        else             state_nxt = ST_FETCH;
`endif
      end
      ST_HALT: halted = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
      ST_PAUSE: if (step) state_nxt = ST_FETCH;
`endif
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      flags_q <= 5'b00000;
    end else begin
      if (state == ST_FETCH && imem_ack)
        ir <= imem_rdata;
      if (state == ST_EXEC && dec_is_alu)
        flags_q <= {alu_d, alu_n, alu_v, alu_c, alu_z};
      if (state == ST_WB && !dec_is_halt)
        pc <= dec_taken ? PC_W'(dec_imm) : pc + PC_W'(1);
    end
  end

  // IR only changes on a fetch ack, so the decoded fields stay stable from
  // DECODE through WB without extra holding registers.
  assign imem_addr = pc;
  assign alu_fs    = dec_fs;
  assign alu_sh    = dec_sh;
  assign rf_ra     = dec_ra;
  assign rf_rb     = dec_rb;
  assign rf_wa     = dec_rd;
  assign rf_wsel   = dec_wsel;
  assign imm       = dec_imm;

endmodule

// File: tb/tb_alu_control_sequencer.sv
module tb_alu_control_sequencer;
  import alu_control_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [3:0]  alu_fs;
  logic [2:0]  alu_sh;
  logic [4:0]  alu_flags;
  logic [2:0]  rf_ra, rf_rb, rf_wa;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic [7:0]  imm;
  logic        halted;
  logic [4:0]  flags_q;

  always #5 clk = ~clk;

  alu_control_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .alu_fs     (alu_fs),
    .alu_sh     (alu_sh),
    .alu_z      (alu_flags[0]),
    .alu_c      (alu_flags[1]),
    .alu_v      (alu_flags[2]),
    .alu_n      (alu_flags[3]),
    .alu_d      (alu_flags[4]),
    .rf_ra      (rf_ra),
    .rf_rb      (rf_rb),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wsel    (rf_wsel),
    .imm        (imm),
    .halted     (halted),
    .flags_q    (flags_q)
  );

  // ALU stand-in: flags depend on operand-A address; unused addresses give noise
  logic [4:0] flag_tab [8];
  initial begin
    for (int i = 0; i < 8; i++) flag_tab[i] = 5'b10111;
    flag_tab[1] = 5'b00000;
    flag_tab[2] = 5'b00001;
    flag_tab[6] = 5'b01010;
  end
  assign alu_flags = flag_tab[rf_ra];

  typedef struct { logic [7:0] addr; int dly; } fetch_t;
  typedef struct {
    logic [2:0] wa; logic [1:0] wsel; logic [7:0] imm; logic [3:0] fs;
    logic [2:0] sh; logic [2:0] ra; logic [2:0] rb; logic [4:0] flags;
  } wr_t;

  fetch_t      fq[$];
  wr_t         wq[$];
  logic [15:0] prog [256];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wait_cnt = 0;
  int          last_hs = 0;
  bit          have_last = 0;
  logic        prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_w(input logic [3:0] fs, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
    return {1'b0, fs, rd, ra, rb, 2'b00};
  endfunction

  function automatic logic [15:0] ctl_w(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [7:0] a);
    return {1'b1, op, 1'b0, rd, a};
  endfunction

  task automatic exp_fetch(input logic [7:0] a, input int d);
    fetch_t f;
    f.addr = a; f.dly = d;
    fq.push_back(f);
  endtask

  task automatic exp_wr(input logic [2:0] wa, input logic [1:0] wsel, input logic [7:0] im,
                        input logic [3:0] fs, input logic [2:0] sh, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [4:0] fl);
    wr_t w;
    w.wa = wa; w.wsel = wsel; w.imm = im; w.fs = fs;
    w.sh = sh; w.ra = ra; w.rb = rb; w.flags = fl;
    wq.push_back(w);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = ctl_w(OP_NOP, 3'd0, 8'h00);
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: acks after the scheduled number of wait cycles, and
  // throws spurious acks with a HALT word while no request is pending.
  always @(posedge clk) begin
    #2;
    if (imem_req) begin
      if (fq.size() > 0 && wait_cnt == fq[0].dly) begin
        imem_ack   = 1'b1;
        imem_rdata = prog[imem_addr];
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
      end
      wait_cnt++;
    end else begin
      wait_cnt   = 0;
      imem_ack   = (cyc % 3 == 0);
      imem_rdata = 16'hF700;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      have_last = 0;
      prev_we   = 1'b0;
    end else begin
      if (imem_req && imem_ack) begin
        if (fq.size() == 0) begin
          check("fetch_unexpected", 1, 0);
        end else begin
          fetch_t f;
          f = fq.pop_front();
          check("fetch_addr", imem_addr, f.addr);
          if (have_last) check("fetch_gap", cyc - last_hs, 4 + f.dly);
          last_hs   = cyc;
          have_last = 1;
        end
      end
      if (rf_we) begin
        check("we_consecutive", prev_we, 0);
        if (wq.size() == 0) begin
          check("we_unexpected", {rf_wa, rf_wsel}, 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("we_wa", rf_wa, w.wa);
          check("we_wsel", rf_wsel, w.wsel);
          check("we_flags", flags_q, w.flags);
          if (w.wsel == WSEL_ALU) begin
            check("we_fs", alu_fs, w.fs);
            check("we_sh", alu_sh, w.sh);
            check("we_ra", rf_ra, w.ra);
            check("we_rb", rf_rb, w.rb);
          end
          if (w.wsel == WSEL_IMM) check("we_imm", imm, w.imm);
        end
      end
      prev_we = rf_we;
    end
  end

  task automatic check_reset_vals();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_fs_sh", {alu_fs, alu_sh}, 0);
    check("rst_ra_rb_wa", {rf_ra, rf_rb, rf_wa}, 0);
    check("rst_we_wsel_imm", {rf_we, rf_wsel, imm}, 0);
    check("rst_halted", halted, 0);
    check("rst_flags", flags_q, 0);
  endtask

  task automatic assert_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("req_after_rst", imem_req, 1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (fq.size() == 0 && wq.size() == 0) break;
    end
    check("drain_pending", fq.size() + wq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase 1: branches, writes, flag latching, PC wrap
    clear_prog();
    prog[8'h00] = alu_w(FS_ADD, 3'd1, 3'd2, 3'd3);
    prog[8'h01] = ctl_w(OP_JZ, 3'd0, 8'h40);
    prog[8'h40] = ctl_w(OP_LDI, 3'd5, 8'hA5);
    prog[8'h41] = alu_w(FS_SUB, 3'd4, 3'd6, 3'd7);
    prog[8'h42] = ctl_w(OP_JZ, 3'd0, 8'h80);
    prog[8'h43] = ctl_w(OP_JN, 3'd0, 8'h60);
    prog[8'h60] = ctl_w(OP_JC, 3'd0, 8'h70);
    prog[8'h70] = alu_w(FS_SHL, 3'd2, 3'd1, 3'd5);
    prog[8'h71] = ctl_w(OP_JC, 3'd0, 8'h20);
    prog[8'h72] = ctl_w(OP_JMP, 3'd0, 8'hFF);
    prog[8'hFF] = ctl_w(OP_IN, 3'd3, 8'h00);
    assert_reset(3);
    exp_fetch(8'h00, 1); exp_fetch(8'h01, 1); exp_fetch(8'h40, 1);
    exp_fetch(8'h41, 0); exp_fetch(8'h42, 2); exp_fetch(8'h43, 0);
    exp_fetch(8'h60, 3); exp_fetch(8'h70, 0); exp_fetch(8'h71, 1);
    exp_fetch(8'h72, 0); exp_fetch(8'hFF, 2); exp_fetch(8'h00, 0);
    exp_wr(3'd1, WSEL_ALU, 8'h00, FS_ADD, 3'd0, 3'd2, 3'd3, 5'b00001);
    exp_wr(3'd5, WSEL_IMM, 8'hA5, 4'h0,   3'd0, 3'd0, 3'd0, 5'b00001);
    exp_wr(3'd4, WSEL_ALU, 8'h00, FS_SUB, 3'd0, 3'd6, 3'd7, 5'b01010);
    exp_wr(3'd2, WSEL_ALU, 8'h00, FS_SHL, 3'd5, 3'd1, 3'd5, 5'b00000);
    exp_wr(3'd3, WSEL_IN,  8'h00, 4'h0,   3'd0, 3'd0, 3'd0, 5'b00000);
    release_reset();
    drain(300);

    // Phase 2: LDI then HALT; halted holds with no fetch or write
    assert_reset(2);
    clear_prog();
    prog[8'h01] = ctl_w(OP_LDI, 3'd7, 8'h3C);
    prog[8'h02] = ctl_w(OP_HALT, 3'd0, 8'h00);
    exp_fetch(8'h00, 0); exp_fetch(8'h01, 2); exp_fetch(8'h02, 0);
    exp_wr(3'd7, WSEL_IMM, 8'h3C, 4'h0, 3'd0, 3'd0, 3'd0, 5'b00000);
    release_reset();
    drain(100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("halt_reached", halted, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_hold", {halted, imem_req, rf_we}, 3'b100);
    end

    // Phase 3: reset while a fetch is outstanding
    assert_reset(2);
    clear_prog();
    exp_fetch(8'h00, 0);
    release_reset();
    drain(50);
    repeat (6) @(negedge clk);
    check("wait_req", imem_req, 1);
    check("wait_addr", imem_addr, 8'h01);
    assert_reset(1);
    exp_fetch(8'h00, 0); exp_fetch(8'h01, 0); exp_fetch(8'h02, 0);
    release_reset();
    drain(50);

`ifdef SEQ_SINGLE_STEP_EN
    // Phase 4: single-step pause after WB; HALT ignores step
    assert_reset(2);
    clear_prog();
    prog[8'h00] = ctl_w(OP_LDI, 3'd6, 8'h11);
    prog[8'h01] = ctl_w(OP_HALT, 3'd0, 8'h00);
    exp_fetch(8'h00, 0);
    exp_wr(3'd6, WSEL_IMM, 8'h11, 4'h0, 3'd0, 3'd0, 3'd0, 5'b00000);
    release_reset();
    drain(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pause_no_req", imem_req, 0);
    end
    exp_fetch(8'h01, 0);
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    @(negedge clk);
    check("step_req", imem_req, 1);
    drain(20);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("step_halt_reached", halted, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 step = (i % 2 == 0);
      @(negedge clk);
      check("step_halt_hold", {halted, imem_req}, 2'b10);
    end
    step = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
